rom_load_demux: RTL

- Sits between the hps_io ioctl download port and the core's ROM/PROM RAMs, i.e. directly upstream of the core's ROM write ports.
- Accepts 16-bit ioctl words, serialises them into two byte writes, and decodes the byte address into one of four ROM regions with a region-relative address.
- Drives ioctl_wait back to the framework.
- Reports load completion, an 8-bit additive checksum and protocol-error flags.

---
 rtl/rom_load_demux_if.sv | 29 ++
 rtl/rom_load_demux.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/rom_load_demux_if.sv
// ioctl download port towards the framework plus the ROM write bus and load status.
// The demux is the slave end; the framework/testbench drives the master end.
interface rom_load_demux_if;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [26:0] ioctl_addr;
   logic [15:0] ioctl_dout;
   logic        ioctl_wait;
   logic [3:0]  rom_we;
   logic [15:0] rom_addr;
   logic [7:0]  rom_data;
   logic        loaded;
   logic        done;
   logic [7:0]  checksum;
   logic        overrun;
   logic        oversize;

   modport master (
      output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
      input  ioctl_wait, rom_we, rom_addr, rom_data,
      input  loaded, done, checksum, overrun, oversize
   );

   modport slave (
      input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
      output ioctl_wait, rom_we, rom_addr, rom_data,
      output loaded, done, checksum, overrun, oversize
   );
endinterface

// File: rtl/rom_load_demux.sv
// Splits 16-bit ioctl download words into two byte writes, routes each byte to one
// of four ROM regions with a region-relative address, and tracks load status.
module rom_load_demux #(
   parameter logic [23:0] R1_BASE = 24'h00E000,
   parameter logic [23:0] R2_BASE = 24'h012000,
   parameter logic [23:0] R3_BASE = 24'h01A000,
   parameter logic [23:0] ROM_END = 24'h01A120
) (
   input logic             clk_sys,
   input logic             reset_n,
   rom_load_demux_if.slave bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LO   = 2'd1;
   localparam logic [1:0] HI   = 2'd2;
   localparam logic [1:0] FIN  = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [26:0] addr_q, addr_d;
   logic [15:0] word_q, word_d;
   logic        dlPrev_q;
   logic        finPending_q, finPending_d;
   logic        wait_q, wait_d;
   logic [3:0]  romWe_q, romWe_d;
   logic [15:0] romAddr_q, romAddr_d;
   logic [7:0]  romData_q, romData_d;
   logic        loaded_q, loaded_d;
   logic        done_q, done_d;
   logic [7:0]  checksum_q, checksum_d;
   logic        overrun_q, overrun_d;
   logic        oversize_q, oversize_d;

   logic        dlRise, dlFall, accept, clearFlags;
   logic        emitValid, inRange, writeHit;
   logic [26:0] emitAddr;
   logic [7:0]  emitByte;
   logic [3:0]  regionOh;
   logic [15:0] regionBase;

   assign dlRise     = bus.ioctl_download & ~dlPrev_q;
   assign dlFall     = ~bus.ioctl_download & dlPrev_q;
   assign accept     = (state_q == IDLE) & bus.ioctl_download & bus.ioctl_wr;
   assign clearFlags = (state_q == IDLE) & dlRise;

   // The low byte is decoded straight off the bus in the strobe cycle so that it is
   // already on the ROM port during LO; the high byte comes from the latched word.
   always_comb begin
      emitValid  = accept | (state_q == LO);
      emitAddr   = (state_q == LO) ? addr_q + 27'd1 : bus.ioctl_addr;
      emitByte   = (state_q == LO) ? word_q[15:8] : bus.ioctl_dout[7:0];
      inRange    = 1'b1;
      regionOh   = 4'b0000;
      regionBase = 16'h0000;
      if (emitAddr < {3'b000, R1_BASE}) begin
         regionOh = 4'b0001;
      end else if (emitAddr < {3'b000, R2_BASE}) begin
         regionOh   = 4'b0010;
         regionBase = R1_BASE[15:0];
      end else if (emitAddr < {3'b000, R3_BASE}) begin
         regionOh   = 4'b0100;
         regionBase = R2_BASE[15:0];
      end else if (emitAddr < {3'b000, ROM_END}) begin
         regionOh   = 4'b1000;
         regionBase = R3_BASE[15:0];
      end else begin
         inRange = 1'b0;
      end
      writeHit = emitValid & inRange;
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      word_d       = word_q;
      finPending_d = finPending_q;
      case (state_q)
         IDLE: begin
            if (dlFall) begin
               state_d = FIN;
            end else if (accept) begin
               state_d = LO;
               addr_d  = bus.ioctl_addr;
               word_d  = bus.ioctl_dout;
            end
         end
         LO: begin
            state_d = HI;
            if (dlFall) finPending_d = 1'b1;
         end
         HI: begin
            state_d      = (finPending_q | dlFall) ? FIN : IDLE;
            finPending_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   // Region-relative address only needs the low 16 bits, so the subtraction is
   // done modulo 2^16; the region sizes all fit.
   always_comb begin
      romWe_d    = writeHit ? regionOh : 4'b0000;
      romAddr_d  = writeHit ? (emitAddr[15:0] - regionBase) : romAddr_q;
      romData_d  = writeHit ? emitByte : romData_q;
      checksum_d = (clearFlags ? 8'h00 : checksum_q) + (writeHit ? emitByte : 8'h00);
      oversize_d = (clearFlags ? 1'b0 : oversize_q) | (emitValid & ~inRange);
      overrun_d  = (clearFlags ? 1'b0 : overrun_q)
                   | ((state_q != IDLE) & bus.ioctl_download & bus.ioctl_wr);
      loaded_d   = (clearFlags ? 1'b0 : loaded_q) | (state_d == FIN);
      done_d     = (state_d == FIN);
      wait_d     = (state_d == LO) | (state_d == HI);
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         word_q       <= '0;
         dlPrev_q     <= 1'b0;
         finPending_q <= 1'b0;
         wait_q       <= 1'b0;
         romWe_q      <= '0;
         romAddr_q    <= '0;
         romData_q    <= '0;
         loaded_q     <= 1'b0;
         done_q       <= 1'b0;
         checksum_q   <= '0;
         overrun_q    <= 1'b0;
         oversize_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         word_q       <= word_d;
         dlPrev_q     <= bus.ioctl_download;
         finPending_q <= finPending_d;
         wait_q       <= wait_d;
         romWe_q      <= romWe_d;
         romAddr_q    <= romAddr_d;
         romData_q    <= romData_d;
         loaded_q     <= loaded_d;
         done_q       <= done_d;
         checksum_q   <= checksum_d;
         overrun_q    <= overrun_d;
         oversize_q   <= oversize_d;
      end
   end

   assign bus.ioctl_wait = wait_q;
   assign bus.rom_we     = romWe_q;
   assign bus.rom_addr   = romAddr_q;
   assign bus.rom_data   = romData_q;
   assign bus.loaded     = loaded_q;
   assign bus.done       = done_q;
   assign bus.checksum   = checksum_q;
   assign bus.overrun    = overrun_q;
   assign bus.oversize   = oversize_q;

endmodule
